kdf_session_initiator: RTL
==========================

Name: kdf_session_initiator

Overview:
Drives the FPGA side of a session-key handshake.
- Receives the 32-byte client nonce over a byte stream.
- Generates a 256-bit FPGA nonce and returns it to the client.
- Sequences the key-derivation block through its start/complete interface.
- Latches and publishes the derived session key.

Sits between the host byte transport and the key-derivation block inside the security agent.

Parameters:
- LFSR_SEED, 32'hACE1_2D5B: reset seed of the internal nonce LFSR. Must be non-zero.
- KDF_TIMEOUT, 64: max cycles in KDF_WAIT before error. Valid range 1..65535.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- secret_valid  in  1  shared secret available; handshake starts only while high
- abort  in  1  synchronous abort; returns FSM to IDLE
- rx_data  in  8  client nonce byte, MSB-first
- rx_valid  in  1  rx byte valid
- rx_ready  out  1  rx byte accepted when rx_valid&&rx_ready
- tx_data  out  8  FPGA nonce byte, MSB-first
- tx_valid  out  1  tx byte valid
- tx_ready  in  1  tx byte taken when tx_valid&&tx_ready
- kdf_start  out  1  one-cycle start pulse to the key-derivation block
- kdf_nonce_fpga  out  256  FPGA nonce presented to the key-derivation block
- kdf_nonce_client  out  256  client nonce presented to the key-derivation block
- kdf_complete  in  1  derivation-done level from the key-derivation block
- kdf_key  in  256  derived key from the key-derivation block
- session_key  out  256  latched session key
- key_valid  out  1  session_key is valid
- error  out  1  sticky timeout flag; cleared on next handshake start

Behaviour:
Reset and clocking:
- Reset reset_n, asynchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: all outputs 0; LFSR = LFSR_SEED; FSM = IDLE.

LFSR:
- 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
- Steps every cycle, independent of FSM state.

FSM states:
- IDLE: rx_ready=0. When secret_valid=1, go to RX_NONCE: clear byte_cnt and error, drop key_valid.
- RX_NONCE: rx_ready=1.
  - Each accepted byte: kdf_nonce_client <= {kdf_nonce_client[247:0], rx_data}; kdf_nonce_fpga <= {kdf_nonce_fpga[223:0], lfsr}; byte_cnt++.
  - After 32nd byte (byte_cnt 31 accepted), go to TX_NONCE with byte_cnt=0.
- TX_NONCE:
  - tx_valid=1; tx_data = kdf_nonce_fpga[255-8*byte_cnt -: 8].
  - tx_data is held stable while tx_valid&&!tx_ready.
  - After 32nd handshake, go to KDF_START.
- KDF_START: kdf_start=1 for exactly this cycle; then KDF_SETTLE.
- KDF_SETTLE: one cycle. kdf_complete is ignored, because a stale high level from the previous run may persist until the key-derivation block sees start. Load timer=0; go to KDF_WAIT.
- KDF_WAIT:
  - kdf_complete=1: session_key <= kdf_key; key_valid <= 1 next cycle; go to IDLE.
  - Otherwise timer++. At timer==KDF_TIMEOUT-1 without complete: error<=1; go to IDLE.

Boundary conditions:
- key_valid stays high until next handshake start, abort, or reset.
- secret_valid dropping mid-handshake: ignored. The handshake completes.
- abort in any non-IDLE state: next state IDLE. rx_ready/tx_valid/kdf_start deasserted next cycle. key_valid unchanged. error unchanged.
- abort and kdf_complete in the same cycle: abort wins; key is not latched.
- rx_valid outside RX_NONCE: ignored, since rx_ready=0.
- byte_cnt is 5 bits; wrap at 32 is the terminal condition and never overflows further.
- Reset mid-operation: immediate return to reset values; partial nonces are discarded.

Optional Feature:
KEY_ZEROIZE_EN
- Defined:
  - On abort, timeout, or new handshake start, session_key, kdf_nonce_client and kdf_nonce_fpga are cleared to 0 on the next cycle.
  - After a successful key latch, the nonce registers are also cleared.
- Undefined: these registers retain their values until overwritten.

Decomposition:
- Shared package (security-agent wide):
  - FSM state enum: IDLE, RX_NONCE, TX_NONCE, KDF_START, KDF_SETTLE, KDF_WAIT.
  - NONCE_BYTES=32, KEY_W=256, LFSR_POLY=32'h8020_0003.
- One natural sub-module: nonce_lfsr32 (free-running Galois LFSR, seed parameter, 32-bit output).

Test Plan:
- Nominal handshake: secret_valid=1; send client bytes 0x00..0x1F with rx_valid always high; tx_ready=1; KDF model asserts complete 11 cycles after start.
  - Expect kdf_nonce_client = 256'h000102…1F.
  - Expect 32 tx bytes equal to the model LFSR nonce, MSB-first.
  - Expect exactly one kdf_start pulse; session_key = model key; key_valid=1.
- Tx backpressure: tx_ready toggled 1-0-0-1 pattern → tx_data stable during stalls; 32 distinct handshakes; no dropped or duplicated byte.
- Stale complete: kdf_complete held high from the prior run, dropping 1 cycle after start → no key latch in KDF_SETTLE; latch only on the new complete.
- Timeout: KDF_TIMEOUT=8, complete never asserted → error=1 exactly 8 cycles after entering KDF_WAIT; FSM in IDLE; key_valid=0.
- Abort mid-RX: abort after byte 10 → rx_ready=0 next cycle; a subsequent full handshake produces correct nonces, with no leftover bytes.
- Zeroize (KEY_ZEROIZE_EN defined): complete a handshake, then abort during the next RX → session_key==0, both nonce registers==0.

Source files
------------

// File: rtl/kdf_session_initiator_pkg.sv
// Shared security-agent definitions for the session-key handshake.
// Includes the FSM state encoding, key/nonce widths and the nonce LFSR polynomial.
package kdf_session_initiator_pkg;

    localparam int unsigned NONCE_BYTES = 32;
    localparam int unsigned KEY_W       = 256;
    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RX_NONCE   = 3'd1,
        TX_NONCE   = 3'd2,
        KDF_START  = 3'd3,
        KDF_SETTLE = 3'd4,
        KDF_WAIT   = 3'd5
    } kdf_state_e;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/kdf_session_initiator_nonce_lfsr32.sv
// Free-running 32-bit Galois LFSR used as the FPGA nonce source.
module nonce_lfsr32
    import kdf_session_initiator_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2D5B
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] lfsr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

endmodule

// File: rtl/kdf_session_initiator.sv
// FPGA side of the session-key handshake: client nonce in, FPGA nonce out, KDF sequencing.
// Optional build macro KEY_ZEROIZE_EN clears key/nonce registers on abort, timeout and restart.
module kdf_session_initiator
    import kdf_session_initiator_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2D5B,
    parameter int unsigned KDF_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             secret_valid,
    input  logic             abort,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             kdf_start,
    output logic [KEY_W-1:0] kdf_nonce_fpga,
    output logic [KEY_W-1:0] kdf_nonce_client,
    input  logic             kdf_complete,
    input  logic [KEY_W-1:0] kdf_key,
    output logic [KEY_W-1:0] session_key,
    output logic             key_valid,
    output logic             error
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_RX     = RX_NONCE;
    localparam logic [2:0] S_TX     = TX_NONCE;
    localparam logic [2:0] S_START  = KDF_START;
    localparam logic [2:0] S_SETTLE = KDF_SETTLE;
    localparam logic [2:0] S_WAIT   = KDF_WAIT;

    localparam logic [4:0]  LAST_BYTE  = 5'(NONCE_BYTES - 1);
    localparam logic [15:0] TIMER_LAST = 16'(KDF_TIMEOUT - 1);

    logic [2:0]  state;
    logic [4:0]  byte_cnt;
    logic [15:0] timer;
    logic [31:0] lfsr;

    nonce_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .lfsr    (lfsr)
    );

    assign rx_ready  = (state == S_RX);
    assign tx_valid  = (state == S_TX);
    assign kdf_start = (state == S_START);
    // {~byte_cnt, 3'b111} == 255 - 8*byte_cnt, the MSB of the current byte
    assign tx_data   = kdf_nonce_fpga[{~byte_cnt, 3'b111} -: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            byte_cnt         <= '0;
            timer            <= '0;
            kdf_nonce_client <= '0;
            kdf_nonce_fpga   <= '0;
            session_key      <= '0;
            key_valid        <= 1'b0;
            error            <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
            if (state == S_IDLE) begin
                key_valid <= 1'b0;
            end
`ifdef KEY_ZEROIZE_EN
            session_key      <= '0;
            kdf_nonce_client <= '0;
            kdf_nonce_fpga   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (secret_valid) begin
                        state     <= S_RX;
                        byte_cnt  <= '0;
                        error     <= 1'b0;
                        key_valid <= 1'b0;
`ifdef KEY_ZEROIZE_EN
                        session_key      <= '0;
                        kdf_nonce_client <= '0;
                        kdf_nonce_fpga   <= '0;
`endif
                    end
                end
                S_RX: begin
                    if (rx_valid) begin
                        kdf_nonce_client <= {kdf_nonce_client[KEY_W-9:0], rx_data};
                        kdf_nonce_fpga   <= {kdf_nonce_fpga[KEY_W-33:0], lfsr};
                        byte_cnt         <= byte_cnt + 5'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= S_TX;
                        end
                    end
                end
                S_TX: begin
                    if (tx_ready) begin
                        byte_cnt <= byte_cnt + 5'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    // complete may still be high from the previous run here
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (kdf_complete) begin
                        session_key <= kdf_key;
                        key_valid   <= 1'b1;
                        state       <= S_IDLE;
`ifdef KEY_ZEROIZE_EN
                        kdf_nonce_client <= '0;
                        kdf_nonce_fpga   <= '0;
`endif
                    end else if (timer == TIMER_LAST) begin
                        error <= 1'b1;
                        state <= S_IDLE;
`ifdef KEY_ZEROIZE_EN
                        session_key      <= '0;
                        kdf_nonce_client <= '0;
                        kdf_nonce_fpga   <= '0;
`endif
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
